// File: rtl/tt_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_cond_pkg
// Purpose  : Shared defaults and state type for the pad-input conditioning path.
// Revision : 1.0
// ============================================================================
package tt_cond_pkg;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DEBOUNCE    = 1000;
   localparam int EDGE_CNT_W      = 8;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_QUALIFY = 1'b1
   } deb_state_t;

endpackage : tt_cond_pkg
`default_nettype wire

// File: rtl/input_debounce_sync_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Purpose  : Plain multi-flop synchroniser with asynchronous active-low reset.
// Revision : 1.0
// ============================================================================
module sync_chain #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[SYNC_STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/input_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce_sync
// Purpose  : Synchronise and debounce one pad input; clean level, edge pulses, edge count.
// Revision : 1.0
// ============================================================================
module input_debounce_sync
   import tt_cond_pkg::*;
#(
   parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int   CNT_W           = 16,
   parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  din_raw,
   output logic                  dout,
   output logic                  rise,
   output logic                  fall,
   output logic                  busy,
   output logic [EDGE_CNT_W-1:0] edge_cnt
);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("input_debounce_sync: SYNC_STAGES must be >= 2");
      end
      if ((DEBOUNCE_CYCLES < 1) ||
          (64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_debounce
         $error("input_debounce_sync: DEBOUNCE_CYCLES out of range for CNT_W");
      end
   endgenerate

   // The final count value: the new level has then been seen DEBOUNCE_CYCLES times.
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                  w_s;
   deb_state_t            w_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  r_dout;
   logic                  w_dout_nxt;
   logic                  r_rise;
   logic                  w_rise_nxt;
   logic                  r_fall;
   logic                  w_fall_nxt;
   logic [EDGE_CNT_W-1:0] r_edge_cnt;
   logic [EDGE_CNT_W-1:0] w_edge_nxt;

   sync_chain #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (din_raw),
      .o_q   (w_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_dout     <= RESET_LEVEL;
         r_rise     <= 1'b0;
         r_fall     <= 1'b0;
         r_edge_cnt <= '0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_dout     <= w_dout_nxt;
         r_rise     <= w_rise_nxt;
         r_fall     <= w_fall_nxt;
         r_edge_cnt <= w_edge_nxt;
      end
   end

   always_comb begin
      w_state    = (r_cnt != '0) ? ST_QUALIFY : ST_STABLE;
      w_cnt_nxt  = r_cnt;
      w_dout_nxt = r_dout;
      w_rise_nxt = 1'b0;
      w_fall_nxt = 1'b0;
      w_edge_nxt = r_edge_cnt;
      if (!en) begin
         w_cnt_nxt = '0;
      end else if (w_s == r_dout) begin
         w_cnt_nxt = '0;
      end else if (r_cnt == c_LAST) begin
         w_dout_nxt = w_s;
         w_cnt_nxt  = '0;
         w_rise_nxt = w_s;
         w_fall_nxt = !w_s;
         w_edge_nxt = r_edge_cnt + EDGE_CNT_W'(1);
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   assign dout     = r_dout;
   assign rise     = r_rise;
   assign fall     = r_fall;
   assign busy     = (w_state == ST_QUALIFY);
   assign edge_cnt = r_edge_cnt;

endmodule : input_debounce_sync
`default_nettype wire
